// File: rtl/scr_pkg.sv
// Shared constants and types for the x^58 self-synchronous scrambler.
// Holds LFSR width, tap positions, mode enum and the reset header value.
package scr_pkg;

  localparam int SCR_STATE_W = 58;
  localparam int SCR_TAP_A   = 38;
  localparam int SCR_TAP_B   = 57;

  typedef enum logic {
    SCR_MODE_SCRAMBLE   = 1'b0,
    SCR_MODE_DESCRAMBLE = 1'b1
  } scr_mode_t;

  typedef logic [SCR_STATE_W-1:0] scr_state_t;

  localparam logic [1:0] SCR_HEAD_RST = 2'b10;

  // Feedback term of 1 + x^39 + x^58 taken from the current state.
  function automatic logic scr_tap(input scr_state_t s);
    return s[SCR_TAP_A] ^ s[SCR_TAP_B];
  endfunction

endpackage

// File: rtl/scr_lfsr_step.sv
// Combinational DATA_W-bit advance of the x^58 scrambler/descrambler.
// Ports: state/data in, out (processed payload) and state_next.
module scr_lfsr_step
  import scr_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int MODE   = 0
) (
  input  scr_state_t        state,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] out,
  output scr_state_t        state_next
);

  localparam bit DESCR = (MODE == int'(SCR_MODE_DESCRAMBLE));

  // Unrolled serial evaluation, bit 0 first; later bits see the
  // feedback produced by earlier bits of the same word.
  always_comb begin
    scr_state_t s;
    logic       f;
    s   = state;
    f   = 1'b0;
    out = '0;
    for (int i = 0; i < DATA_W; i++) begin
      out[i] = data[i] ^ scr_tap(s);
      f      = DESCR ? data[i] : out[i];
      s      = {s[SCR_STATE_W-2:0], f};
    end
    state_next = s;
  end

endmodule

// File: rtl/scrambler_x58.sv
// 64b/66b-style x^58 scrambler with a one-entry valid/ready register.
// Ports: clk_i, rst_i (sync, active-high); data_i/head_i/data_vld_i,
// data_rdy_o upstream; data_o/head_o/data_vld_o, data_rdy_i downstream.
// Optional macro SCR_BYPASS_EN adds bypass_i (raw pass, state held).
module scrambler_x58
  import scr_pkg::*;
#(
  parameter int         DATA_W = 64,
  parameter int         MODE   = 0,
  parameter scr_state_t SEED   = 58'h3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [1:0]        head_i,
  input  logic              data_vld_i,
  output logic              data_rdy_o,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        head_o,
  output logic              data_vld_o,
  input  logic              data_rdy_i
`ifdef SCR_BYPASS_EN
  ,
  input  logic              bypass_i
`endif
);

  scr_state_t        state;
  scr_state_t        step_next;
  scr_state_t        state_d;
  logic [DATA_W-1:0] step_out;
  logic [DATA_W-1:0] word_d;
  logic              take;

  scr_lfsr_step #(
    .DATA_W (DATA_W),
    .MODE   (MODE)
  ) u_step (
    .state      (state),
    .data       (data_i),
    .out        (step_out),
    .state_next (step_next)
  );

  // Register may refill in the same cycle it drains.
  assign data_rdy_o = !data_vld_o || data_rdy_i;
  assign take       = data_vld_i && data_rdy_o;

  always_comb begin
    word_d  = step_out;
    state_d = step_next;
`ifdef SCR_BYPASS_EN
    if (bypass_i) begin
      word_d  = data_i;
      state_d = state;
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= SEED;
      data_o     <= '0;
      head_o     <= SCR_HEAD_RST;
      data_vld_o <= 1'b0;
    end else if (take) begin
      state      <= state_d;
      data_o     <= word_d;
      head_o     <= head_i;
      data_vld_o <= 1'b1;
    end else if (data_rdy_i) begin
      data_vld_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_scrambler_x58.sv
// Randomized scoreboard bench for scrambler_x58: 64-bit scrambler in
// loopback to a descrambler, a 32-bit twin, and a zero-seed instance.
module tb_scrambler_x58;

  localparam logic [57:0] SEED_A = 58'h2A5_F00D_1234_5678;
  localparam logic [57:0] SEED_B = 58'h155_0BAD_CAFE_0001;

  typedef struct {
    logic [63:0] d;
    logic [1:0]  h;
    logic        c;
  } orig_t;

  typedef struct {
    logic        b;
    logic [1:0]  h;
    logic [31:0] d;
    logic [31:0] e;
  } half_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [63:0] s_din = '0;
  logic [1:0]  s_head = '0;
  logic        s_vld = 1'b0;
  logic        s_byp = 1'b0;
  logic        s_rdy_o;
  logic [63:0] s_dout;
  logic [1:0]  s_hout;
  logic        s_vout;

  logic        d_rdy_o;
  logic [63:0] d_dout;
  logic [1:0]  d_hout;
  logic        d_vout;
  logic        d_ordy = 1'b0;

  logic [31:0] h_din = '0;
  logic [1:0]  h_head = '0;
  logic        h_vld = 1'b0;
  logic        h_byp = 1'b0;
  logic        h_rdy_o;
  logic [31:0] h_dout;
  logic [1:0]  h_hout;
  logic        h_vout;
  logic        h_ordy = 1'b0;

  logic [63:0] z_din = '0;
  logic        z_vld = 1'b0;
  logic        z_rdy_o;
  logic [63:0] z_dout;
  logic [1:0]  z_hout;
  logic        z_vout;
  logic        zero_bit = 1'b0;
  logic        one_bit = 1'b1;
  logic [1:0]  zero_head = '0;

  logic        force_stall = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int wcnt = 0;
  logic prev_byp = 1'b0;

  bit          hist[$];
  logic [65:0] q_s[$];
  orig_t       q_o[$];
  half_t       q_h_in[$];
  logic [33:0] q_h_exp[$];

  scrambler_x58 #(.DATA_W(64), .MODE(0), .SEED(SEED_A)) u_scr (
    .clk_i(clk), .rst_i(rst),
    .data_i(s_din), .head_i(s_head),
    .data_vld_i(s_vld), .data_rdy_o(s_rdy_o),
    .data_o(s_dout), .head_o(s_hout),
    .data_vld_o(s_vout), .data_rdy_i(d_rdy_o)
`ifdef SCR_BYPASS_EN
    , .bypass_i(s_byp)
`endif
  );

  scrambler_x58 #(.DATA_W(64), .MODE(1), .SEED(SEED_B)) u_dsc (
    .clk_i(clk), .rst_i(rst),
    .data_i(s_dout), .head_i(s_hout),
    .data_vld_i(s_vout), .data_rdy_o(d_rdy_o),
    .data_o(d_dout), .head_o(d_hout),
    .data_vld_o(d_vout), .data_rdy_i(d_ordy)
`ifdef SCR_BYPASS_EN
    , .bypass_i(zero_bit)
`endif
  );

  scrambler_x58 #(.DATA_W(32), .MODE(0), .SEED(SEED_A)) u_w32 (
    .clk_i(clk), .rst_i(rst),
    .data_i(h_din), .head_i(h_head),
    .data_vld_i(h_vld), .data_rdy_o(h_rdy_o),
    .data_o(h_dout), .head_o(h_hout),
    .data_vld_o(h_vout), .data_rdy_i(h_ordy)
`ifdef SCR_BYPASS_EN
    , .bypass_i(h_byp)
`endif
  );

  scrambler_x58 #(.DATA_W(64), .MODE(0), .SEED(58'h0)) u_z (
    .clk_i(clk), .rst_i(rst),
    .data_i(z_din), .head_i(zero_head),
    .data_vld_i(z_vld), .data_rdy_o(z_rdy_o),
    .data_o(z_dout), .head_o(z_hout),
    .data_vld_o(z_vout), .data_rdy_i(one_bit)
`ifdef SCR_BYPASS_EN
    , .bypass_i(zero_bit)
`endif
  );

  task automatic chk(input string nm, input logic [65:0] act,
                     input logic [65:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference: the transmitted line is a bit sequence y[n] with
  // y[n] = d[n] ^ y[n-39] ^ y[n-58]; seed bits prefill the history.
  task automatic model_reset(input logic [57:0] seed);
    hist.delete();
    for (int k = 57; k >= 0; k--) hist.push_back(seed[k]);
  endtask

  task automatic model_word(input logic [63:0] d, output logic [63:0] y);
    int n;
    for (int i = 0; i < 64; i++) begin
      n = hist.size();
      y[i] = d[i] ^ hist[n-39] ^ hist[n-58];
      hist.push_back(y[i]);
      void'(hist.pop_front());
    end
  endtask

  task automatic run_stream(input int n);
    int got;
    int cyc;
    logic [63:0] y;
    half_t hh;
    got = 0;
    cyc = 0;
    while (got < n && cyc < n * 50) begin
      @(posedge clk);
      #1;
      s_vld = ($urandom % 4) != 0;
      s_din = {$urandom, $urandom};
      s_head = 2'($urandom);
`ifdef SCR_BYPASS_EN
      s_byp = ($urandom % 10) == 0;
`endif
      @(negedge clk);
      cyc++;
      if (s_vld && s_rdy_o) begin
        if (s_byp) y = s_din;
        else model_word(s_din, y);
        q_s.push_back({s_head, y});
        q_o.push_back('{d: s_din, h: s_head,
                        c: (wcnt != 0) && !s_byp && !prev_byp});
        hh = '{b: s_byp, h: s_head, d: s_din[31:0], e: y[31:0]};
        q_h_in.push_back(hh);
        hh = '{b: s_byp, h: s_head, d: s_din[63:32], e: y[63:32]};
        q_h_in.push_back(hh);
        prev_byp = s_byp;
        wcnt++;
        got++;
      end
    end
    @(posedge clk);
    #1;
    s_vld = 1'b0;
    s_byp = 1'b0;
    if (got < n) chk("stream_timeout", 66'(got), 66'(n));
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    while ((q_s.size() + q_o.size() + q_h_in.size() + q_h_exp.size()) != 0
           && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    chk("drain_left", 66'(q_s.size() + q_o.size() + q_h_in.size()
        + q_h_exp.size()), 66'd0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      d_ordy = force_stall ? 1'b0 : (($urandom % 4) != 0);
      h_ordy = ($urandom % 3) != 0;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!force_stall && q_h_in.size() > 0 && ($urandom % 4) != 0) begin
        h_vld  = 1'b1;
        h_din  = q_h_in[0].d;
        h_head = q_h_in[0].h;
        h_byp  = q_h_in[0].b;
      end else begin
        h_vld = 1'b0;
        h_byp = 1'b0;
      end
      @(negedge clk);
      if (h_vld && h_rdy_o && !rst) begin
        q_h_exp.push_back({q_h_in[0].h, q_h_in[0].e});
        void'(q_h_in.pop_front());
      end
    end
  end

  logic        prev_stall = 1'b0;
  logic [63:0] prev_d;
  logic [1:0]  prev_h;
  logic [57:0] prev_st;

  always @(negedge clk) begin
    logic [65:0] e;
    logic [33:0] e32;
    orig_t o;
    if (!rst) begin
      chk("rdy_rule", 66'(s_rdy_o), 66'(!s_vout || d_rdy_o));
      if (prev_stall) begin
        chk("stall_vld", 66'(s_vout), 66'd1);
        chk("stall_data", 66'(s_dout), 66'(prev_d));
        chk("stall_head", 66'(s_hout), 66'(prev_h));
        chk("stall_state", 66'(u_scr.state), 66'(prev_st));
      end
      if (s_vout && d_rdy_o) begin
        if (q_s.size() == 0) chk("scr_unexpected", 66'd1, 66'd0);
        else begin
          e = q_s.pop_front();
          chk("scr_out", {s_hout, s_dout}, e);
        end
      end
      if (d_vout && d_ordy) begin
        if (q_o.size() == 0) chk("dsc_unexpected", 66'd1, 66'd0);
        else begin
          o = q_o.pop_front();
          chk("dsc_head", 66'(d_hout), 66'(o.h));
          if (o.c) chk("loopback", 66'(d_dout), 66'(o.d));
        end
      end
      if (h_vout && h_ordy) begin
        if (q_h_exp.size() == 0) chk("w32_unexpected", 66'd1, 66'd0);
        else begin
          e32 = q_h_exp.pop_front();
          chk("w32_out", 66'({h_hout, h_dout}), 66'(e32));
        end
      end
    end
    prev_stall = s_vout && !d_rdy_o && !rst;
    prev_d  = s_dout;
    prev_h  = s_hout;
    prev_st = u_scr.state;
  end

  initial begin
    model_reset(SEED_A);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_vld", 66'(s_vout), 66'd0);
    chk("rst_head", 66'(s_hout), 66'(2'b10));
    chk("rst_data", 66'(s_dout), 66'd0);
    chk("rst_rdy", 66'(s_rdy_o), 66'd1);
    chk("rst_state", 66'(u_scr.state), 66'(SEED_A));
    chk("rst_dsc_state", 66'(u_dsc.state), 66'(SEED_B));

    @(posedge clk);
    #1;
    z_vld = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk("zero_vld", 66'(z_vout), 66'd1);
        chk("zero_data", 66'(z_dout), 66'd0);
        chk("zero_state", 66'(u_z.state), 66'd0);
      end
      if (i == 9) begin
        @(posedge clk);
        #1;
        z_vld = 1'b0;
      end
    end

    fork
      run_stream(400);
      begin
        repeat (60) @(posedge clk);
        #2;
        force_stall = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        force_stall = 1'b0;
      end
    join
    drain();

    force_stall = 1'b1;
    run_stream(2);
    @(negedge clk);
    chk("pre_rst_vld", 66'(s_vout), 66'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q_s.delete();
    q_o.delete();
    q_h_in.delete();
    q_h_exp.delete();
    model_reset(SEED_A);
    wcnt = 0;
    prev_byp = 1'b0;
    @(negedge clk);
    chk("mid_rst_vld", 66'(s_vout), 66'd0);
    chk("mid_rst_head", 66'(s_hout), 66'(2'b10));
    chk("mid_rst_state", 66'(u_scr.state), 66'(SEED_A));
    chk("mid_rst_rdy", 66'(s_rdy_o), 66'd1);
    chk("mid_rst_w32_vld", 66'(h_vout), 66'd0);
    force_stall = 1'b0;

    run_stream(600);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
